// File: rtl/decodificador_pwm_pkg.sv
// Shared PWM definitions: FSM encodings, default timing
// constants and the width classifier.
package decodificador_pwm_pkg;

  typedef enum logic [1:0] {
    AGUARDA = 2'b00,
    ALTO    = 2'b01,
    BAIXO   = 2'b10,
    TIMEOUT = 2'b11
  } estado_t;

  typedef enum logic [1:0] {
    PUB_NADA    = 2'b00,
    PUB_PERIODO = 2'b01,
    PUB_BAIXO   = 2'b10,
    PUB_ALTO    = 2'b11
  } pub_t;

  localparam int unsigned DEF_CONF_PERIODO = 1250;
  localparam int unsigned DEF_LARGURA_00   = 0;
  localparam int unsigned DEF_LARGURA_01   = 250;
  localparam int unsigned DEF_LARGURA_10   = 500;
  localparam int unsigned DEF_LARGURA_11   = 750;
  localparam int unsigned DEF_TOLERANCIA   = 25;
  localparam int unsigned DEF_TIMEOUT      = 2500;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Width to code: nearest nominal width, split at
  // the midpoints between neighbouring nominals.
  function automatic logic [1:0] classifica(
    input logic [31:0] w,
    input logic [31:0] l00,
    input logic [31:0] l01,
    input logic [31:0] l10,
    input logic [31:0] l11
  );
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [1:0]  c;
    t0 = (l00 + l01) / 32'd2;
    t1 = (l01 + l10) / 32'd2;
    t2 = (l10 + l11) / 32'd2;
    unique case (1'b1)
      (w < t0):             c = 2'b00;
      (w >= t0 && w < t1): c = 2'b01;
      (w >= t1 && w < t2): c = 2'b10;
      default:              c = 2'b11;
    endcase
    return c;
  endfunction

  // True when |p - conf| exceeds tol.
  function automatic logic fora_tol(
    input logic [31:0] p,
    input logic [31:0] conf,
    input logic [31:0] tol
  );
    logic [31:0] d;
    d = (p >= conf) ? (p - conf) : (conf - p);
    return (d > tol);
  endfunction

endpackage

// File: rtl/decodificador_pwm_sincronizador_borda.sv
// Two-flop synchronizer for pwm_in with registered
// rise/fall pulses and a level aligned to them.
module sincronizador_borda (
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic subida,
  output logic descida,
  output logic nivel
);

  logic s1;
  logic s;
  logic s_prev;

  // Sync chain left unreset: a steady line gives no
  // spurious edge when reset is released.
  always_ff @(posedge clock) begin
    s1     <= pwm_in;
    s      <= s1;
    s_prev <= s;
  end

  // Edge pulses, same delay for both edges.
  always_ff @(posedge clock) begin
    if (!reset) begin
      subida  <= 1'b0;
      descida <= 1'b0;
      nivel   <= 1'b0;
    end else begin
      subida  <= s & ~s_prev;
      descida <= ~s & s_prev;
      nivel   <= s;
    end
  end

endmodule

// File: rtl/decodificador_pwm.sv
// PWM receiver: measures high time and period and
// decodes the width back to a 2-bit code.
module decodificador_pwm
  import decodificador_pwm_pkg::*;
#(
  parameter int unsigned CONF_PERIODO = DEF_CONF_PERIODO,
  parameter int unsigned LARGURA_00   = DEF_LARGURA_00,
  parameter int unsigned LARGURA_01   = DEF_LARGURA_01,
  parameter int unsigned LARGURA_10   = DEF_LARGURA_10,
  parameter int unsigned LARGURA_11   = DEF_LARGURA_11,
  parameter int unsigned TOLERANCIA   = DEF_TOLERANCIA,
  parameter int unsigned TIMEOUT_CIC  = DEF_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [1:0]  largura,
  output logic [31:0] largura_medida,
  output logic [31:0] periodo_medido,
  output logic        pronto,
  output logic        valido,
  output logic        erro_periodo,
  output logic [1:0]  db_estado
);

  localparam logic [31:0] CONF_C = 32'(CONF_PERIODO);
  localparam logic [31:0] L00_C  = 32'(LARGURA_00);
  localparam logic [31:0] L01_C  = 32'(LARGURA_01);
  localparam logic [31:0] L10_C  = 32'(LARGURA_10);
  localparam logic [31:0] L11_C  = 32'(LARGURA_11);
  localparam logic [31:0] TOL_C  = 32'(TOLERANCIA);
  localparam logic [31:0] TO_C   = 32'(TIMEOUT_CIC);

  logic        subida;
  logic        descida;
  logic        nivel;
  estado_t     estado;
  estado_t     estado_nx;
  pub_t        pend;
  pub_t        pend_nx;
  pub_t        pub_to;
  logic        cap_w;
  logic        to_hit;
  logic        fora;
  logic [31:0] cnt;
  logic [31:0] w_reg;
  logic [31:0] p_reg;

  sincronizador_borda u_sinc (
    .clock   (clock),
    .reset   (reset),
    .pwm_in  (pwm_in),
    .subida  (subida),
    .descida (descida),
    .nivel   (nivel)
  );

  assign to_hit    = (cnt >= TO_C);
  assign pub_to    = nivel ? PUB_ALTO : PUB_BAIXO;
  assign fora      = fora_tol(p_reg, CONF_C, TOL_C);
  assign db_estado = estado;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) estado <= AGUARDA;
    else        estado <= estado_nx;
  end

  // Next state; a rise always wins over timeout.
  always_comb begin
    estado_nx = estado;
    pend_nx   = PUB_NADA;
    cap_w     = 1'b0;
    unique case (estado)
      AGUARDA: begin
        if (subida) begin
          estado_nx = ALTO;
        end else if (to_hit) begin
          estado_nx = TIMEOUT;
          pend_nx   = pub_to;
        end
      end
      ALTO: begin
        if (subida) begin
          estado_nx = ALTO;
        end else if (descida) begin
          estado_nx = BAIXO;
          cap_w     = 1'b1;
        end else if (to_hit) begin
          estado_nx = TIMEOUT;
          pend_nx   = pub_to;
        end
      end
      BAIXO: begin
        if (subida) begin
          estado_nx = ALTO;
          pend_nx   = PUB_PERIODO;
        end else if (to_hit) begin
          estado_nx = TIMEOUT;
          pend_nx   = pub_to;
        end
      end
      TIMEOUT: begin
        if (subida) estado_nx = ALTO;
      end
      default: estado_nx = AGUARDA;
    endcase
  end

  // Cycle counter: restarts at 1 on a rise, saturates.
  always_ff @(posedge clock) begin
    if (!reset)              cnt <= 32'd0;
    else if (subida)         cnt <= 32'd1;
    else if (cnt != CNT_MAX) cnt <= cnt + 32'd1;
  end

  // Capture and publish one cycle after the event.
  always_ff @(posedge clock) begin
    if (!reset) begin
      w_reg          <= 32'd0;
      p_reg          <= 32'd0;
      pend           <= PUB_NADA;
      largura        <= 2'b00;
      largura_medida <= 32'd0;
      periodo_medido <= 32'd0;
      pronto         <= 1'b0;
      valido         <= 1'b0;
      erro_periodo   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      pend   <= pend_nx;
      if (cap_w) w_reg <= cnt;
      if (pend_nx != PUB_NADA) p_reg <= cnt;
      unique case (pend)
        PUB_PERIODO: begin
          largura <= classifica(w_reg, L00_C,
                                L01_C, L10_C, L11_C);
          largura_medida <= w_reg;
          periodo_medido <= p_reg;
          erro_periodo   <= fora;
          valido         <= ~fora;
          pronto         <= 1'b1;
        end
        PUB_BAIXO: begin
          largura        <= 2'b00;
          largura_medida <= 32'd0;
          periodo_medido <= 32'd0;
          erro_periodo   <= 1'b0;
          valido         <= 1'b1;
          pronto         <= 1'b1;
        end
        PUB_ALTO: begin
          largura        <= 2'b11;
          largura_medida <= p_reg;
          erro_periodo   <= 1'b1;
          valido         <= 1'b0;
          pronto         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
